// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Shared UART framing-mode constants and arbiter state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [1:0] M8N1 = 2'b00;
    localparam logic [1:0] M8E1 = 2'b01;
    localparam logic [1:0] M8O1 = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_DRAIN  = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ============================================================================
// Module : uart_rr_pick
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int               w_j;
    logic [IDX_W-1:0] w_jidx;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_j    = 0;
        w_jidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j    = (int'(ptr) + i) % NUM_REQ;
            w_jidx = IDX_W'(w_j);
            if (!any && req[w_jidx]) begin
                any            = 1'b1;
                idx            = w_jidx;
                onehot[w_jidx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Round-robin (with burst hold) sharing of one UART transmitter among NUM_REQ
// byte producers; drives the DATA_AVAILABLE/BUSY handshake with launch timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [8*NUM_REQ-1:0] REQ_DATA,
    input  logic [1:0]           MODE_CFG,
    output logic [NUM_REQ-1:0]   ACK,
    output logic [NUM_REQ-1:0]   GNT,
    output logic [7:0]           TX_DATA,
    output logic [1:0]           TX_MODE,
    output logic                 TX_DATA_AVAILABLE,
    input  logic                 TX_BUSY,
    output logic                 ERR,
    input  logic                 ERR_CLR
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = $clog2(BURST_MAX + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [BCNT_W-1:0] c_burst_lim = BCNT_W'(BURST_MAX - 1);
    localparam logic [TCNT_W-1:0] c_tmo_last  = TCNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(NUM_REQ - 1);

    arb_state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr, r_last;
    logic                r_has_last;
    logic [BCNT_W-1:0]   r_burst;
    logic [TCNT_W-1:0]   r_tmo;

    logic [NUM_REQ-1:0]  r_ack, r_gnt;
    logic [7:0]          r_tx_data;
    logic [1:0]          r_tx_mode;
    logic                r_dav, r_err;

    logic [NUM_REQ-1:0]  w_ack_nxt, w_gnt_nxt;
    logic [7:0]          w_data_nxt;
    logic [1:0]          w_mode_nxt;
    logic                w_dav_nxt, w_err_nxt;

    logic [NUM_REQ-1:0]  w_rr_onehot, w_win_onehot;
    logic [IDX_W-1:0]    w_rr_idx, w_win_idx;
    logic                w_rr_any;
    logic [7:0]          w_win_data;
    logic                w_burst_ok, w_capture, w_launch_done, w_timeout, w_drain_done;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (REQ),
        .ptr     (r_ptr),
        .onehot  (w_rr_onehot),
        .idx     (w_rr_idx),
        .any     (w_rr_any)
    );

    // The previous winner keeps the transmitter while it still asks and has burst budget left.
    assign w_burst_ok    = r_has_last && REQ[r_last] && (r_burst < c_burst_lim);
    assign w_win_idx     = w_burst_ok ? r_last : w_rr_idx;
    assign w_win_onehot  = NUM_REQ'(1) << w_win_idx;

    assign w_capture     = (r_state == ARB_IDLE)   && w_rr_any && !TX_BUSY;
    assign w_launch_done = (r_state == ARB_LAUNCH) && TX_BUSY;
    assign w_timeout     = (r_state == ARB_LAUNCH) && !TX_BUSY && (r_tmo == c_tmo_last);
    assign w_drain_done  = (r_state == ARB_DRAIN)  && !TX_BUSY;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_win_data = REQ_DATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_last     <= '0;
            r_has_last <= 1'b0;
            r_burst    <= '0;
            r_tmo      <= '0;
            r_ack      <= '0;
            r_gnt      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_mode  <= 2'b00;
            r_dav      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_gnt     <= w_gnt_nxt;
            r_tx_data <= w_data_nxt;
            r_tx_mode <= w_mode_nxt;
            r_dav     <= w_dav_nxt;
            r_err     <= w_err_nxt;
            if (w_capture) begin
                r_last     <= w_win_idx;
                r_has_last <= 1'b1;
                r_ptr      <= (w_win_idx == c_idx_last) ? '0 : w_win_idx + 1'b1;
                r_burst    <= w_burst_ok ? r_burst + 1'b1 : '0;
                r_tmo      <= '0;
            end else if ((r_state == ARB_LAUNCH) && !TX_BUSY) begin
                r_tmo      <= w_timeout ? '0 : r_tmo + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:   if (w_capture)     w_state_nxt = ARB_LAUNCH;
            ARB_LAUNCH: if (w_launch_done) w_state_nxt = ARB_DRAIN;
                        else if (w_timeout) w_state_nxt = ARB_IDLE;
            ARB_DRAIN:  if (w_drain_done)  w_state_nxt = ARB_IDLE;
            default:                       w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_ack_nxt  = '0;
        w_gnt_nxt  = r_gnt;
        w_data_nxt = r_tx_data;
        w_mode_nxt = r_tx_mode;
        w_dav_nxt  = r_dav;
        w_err_nxt  = r_err;
        case (r_state)
            ARB_IDLE: begin
                if (w_capture) begin
                    w_ack_nxt  = w_win_onehot;
                    w_gnt_nxt  = w_win_onehot;
                    w_data_nxt = w_win_data;
                    w_mode_nxt = MODE_CFG;
                    w_dav_nxt  = 1'b1;
                end else begin
                    w_gnt_nxt  = '0;
                end
            end
            ARB_LAUNCH: begin
                if (w_launch_done) begin
                    w_dav_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_dav_nxt = 1'b0;
                    w_gnt_nxt = '0;
                    w_err_nxt = 1'b1;
                end
            end
            ARB_DRAIN: begin
                if (w_drain_done && !w_burst_ok) begin
                    w_gnt_nxt = '0;
                end
            end
            default: begin
                w_gnt_nxt = '0;
                w_dav_nxt = 1'b0;
            end
        endcase
        if (ERR_CLR) begin
            w_err_nxt = 1'b0;
        end
    end

    assign ACK               = r_ack;
    assign GNT               = r_gnt;
    assign TX_DATA           = r_tx_data;
    assign TX_MODE           = r_tx_mode;
    assign TX_DATA_AVAILABLE = r_dav;
    assign ERR               = r_err;

endmodule

`default_nettype wire
